// File: rtl/ysyx_22050710_mem_stage_mo_if.sv
// Handshake/bus bundle between the multi-outstanding memory stage and its
// neighbours (EXE producer, data-SRAM response, WB consumer, DS bypass).
//   master : EXE/SRAM/WB side, drives entries, responses and ws_allowin
//   slave  : memory stage, drives allowin, retire bus, bypass, stall, error
// Optional YSYX_22050710_MS_PERF_EN adds perf_retire_cnt / perf_stall_cnt.
interface ysyx_22050710_mem_stage_mo_if #(
    parameter int unsigned WORD_WD      = 64,
    parameter int unsigned SRAM_DATA_WD = 64,
    parameter int unsigned GPR_ADDR_WD  = 5,
    parameter int unsigned CSR_ADDR_WD  = 12,
    parameter int unsigned DEBUG_BUS_WD = 161
);
    localparam int unsigned ES_TO_MS_BUS_WD = GPR_ADDR_WD + CSR_ADDR_WD + 8 + 3 * WORD_WD;
    localparam int unsigned MS_TO_WS_BUS_WD = 2 + GPR_ADDR_WD + CSR_ADDR_WD + 2 * WORD_WD;
    localparam int unsigned BYPASS_BUS_WD   = GPR_ADDR_WD + CSR_ADDR_WD + 2 * WORD_WD;

    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_allowin;
    logic [DEBUG_BUS_WD-1:0]    debug_es_to_ms_bus;
    logic                       data_sram_data_ok;
    logic [SRAM_DATA_WD-1:0]    data_sram_rdata;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [DEBUG_BUS_WD-1:0]    debug_ms_to_ws_bus;
    logic [BYPASS_BUS_WD-1:0]   ms_to_ds_bypass_bus;
    logic                       ms_data_stall;
    logic                       ms_resp_err;
`ifdef YSYX_22050710_MS_PERF_EN
    logic [63:0]                perf_retire_cnt;
    logic [63:0]                perf_stall_cnt;

    modport master (
        output es_to_ms_valid, es_to_ms_bus, debug_es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, debug_ms_to_ws_bus,
               ms_to_ds_bypass_bus, ms_data_stall, ms_resp_err,
               perf_retire_cnt, perf_stall_cnt
    );
    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, debug_es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, debug_ms_to_ws_bus,
               ms_to_ds_bypass_bus, ms_data_stall, ms_resp_err,
               perf_retire_cnt, perf_stall_cnt
    );
`else
    modport master (
        output es_to_ms_valid, es_to_ms_bus, debug_es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, debug_ms_to_ws_bus,
               ms_to_ds_bypass_bus, ms_data_stall, ms_resp_err
    );
    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, debug_es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, debug_ms_to_ws_bus,
               ms_to_ds_bypass_bus, ms_data_stall, ms_resp_err
    );
`endif
endinterface

// File: rtl/ysyx_22050710_mem_stage_mo.sv
// Multi-outstanding memory stage between EXE and WB. Holds up to MS_DEPTH
// in-flight entries in program order, attaches data-SRAM responses to the
// oldest entry still waiting, aligns/extends loads and retires the head in order.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   ms (slave)     : EXE entry handshake, SRAM data_ok/rdata, WB handshake,
//                    head bypass bus, load-use stall, sticky response error
// Macro YSYX_22050710_MS_PERF_EN adds 64-bit retire and head-wait counters.
module ysyx_22050710_mem_stage_mo #(
    parameter int unsigned WORD_WD      = 64,
    parameter int unsigned SRAM_DATA_WD = 64,
    parameter int unsigned GPR_ADDR_WD  = 5,
    parameter int unsigned CSR_ADDR_WD  = 12,
    parameter int unsigned MS_DEPTH     = 4,
    parameter int unsigned DEBUG_BUS_WD = 161
) (
    input logic                          i_clk,
    input logic                          i_rst_n,
    ysyx_22050710_mem_stage_mo_if.slave  ms
);
    localparam int unsigned PTR_WD = $clog2(MS_DEPTH);
    localparam int unsigned CNT_WD = PTR_WD + 1;

    typedef struct packed {
        logic [GPR_ADDR_WD-1:0] rd;
        logic [CSR_ADDR_WD-1:0] csr;
        logic                   gpr_wen;
        logic                   csr_wen;
        logic                   mem_ren;
        logic                   mem_wen;
        logic [2:0]             mem_op;
        logic                   csr_sel;
        logic [WORD_WD-1:0]     csrrdata;
        logic [WORD_WD-1:0]     alu_result;
        logic [WORD_WD-1:0]     csr_result;
    } es_entry_t;

    es_entry_t               ent_q   [MS_DEPTH];
    logic [DEBUG_BUS_WD-1:0] dbg_q   [MS_DEPTH];
    logic [SRAM_DATA_WD-1:0] rdata_q [MS_DEPTH];
    logic [MS_DEPTH-1:0]     valid_q;
    logic [MS_DEPTH-1:0]     done_q;
    logic [PTR_WD-1:0]       head_q;
    logic [PTR_WD-1:0]       tail_q;
    logic [CNT_WD-1:0]       count_q;
    logic                    resp_err_q;
    logic                    first_cyc_q;

    es_entry_t           es_ent;
    es_entry_t           head_ent;
    logic                head_valid;
    logic                head_done;
    logic                to_ws_valid;
    logic                fire;
    logic                allowin;
    logic                enq;
    logic                resp_hit;
    logic [PTR_WD-1:0]   resp_idx;
    logic [PTR_WD-1:0]   scan_idx;
    logic                resp_take;
    logic                resp_orphan;
    logic [MS_DEPTH-1:0] load_wait;
    logic [WORD_WD-1:0]  shifted;
    logic [WORD_WD-1:0]  load_val;
    logic [WORD_WD-1:0]  gpr_result;
    logic                byp_en;

    assign es_ent      = es_entry_t'(ms.es_to_ms_bus);
    assign head_ent    = ent_q[head_q];
    assign head_valid  = valid_q[head_q];
    assign head_done   = done_q[head_q];
    assign to_ws_valid = head_valid & head_done;
    assign fire        = to_ws_valid & ms.ws_allowin;
    assign allowin     = (count_q < CNT_WD'(MS_DEPTH)) | fire;
    assign enq         = ms.es_to_ms_valid & allowin;

    // Oldest valid-but-not-done entry owns the next response; non-mem entries
    // are done on enqueue, so the scan skips them naturally.
    always_comb begin
        resp_hit  = 1'b0;
        resp_idx  = head_q;
        scan_idx  = head_q;
        load_wait = '0;
        for (int unsigned i = 0; i < MS_DEPTH; i++) begin
            scan_idx = head_q + PTR_WD'(i);
            if (!resp_hit && valid_q[scan_idx] && !done_q[scan_idx]) begin
                resp_hit = 1'b1;
                resp_idx = scan_idx;
            end
            load_wait[i] = valid_q[i] & ~done_q[i] & ent_q[i].mem_ren;
        end
    end

    // The cycle right after reset swallows a stray data_ok from before reset.
    assign resp_take   = ms.data_sram_data_ok & ~first_cyc_q & resp_hit;
    assign resp_orphan = ms.data_sram_data_ok & ~first_cyc_q & ~resp_hit;

    // Load align/extend from the head's stored response; byte shift only.
    always_comb begin
        shifted = WORD_WD'(rdata_q[head_q] >> {head_ent.alu_result[2:0], 3'b000});
        case (head_ent.mem_op)
            3'b000:  load_val = {{(WORD_WD-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_val = {{(WORD_WD-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {{(WORD_WD-32){shifted[31]}}, shifted[31:0]};
            3'b011:  load_val = shifted;
            3'b100:  load_val = {{(WORD_WD-8){1'b0}},  shifted[7:0]};
            3'b101:  load_val = {{(WORD_WD-16){1'b0}}, shifted[15:0]};
            3'b110:  load_val = {{(WORD_WD-32){1'b0}}, shifted[31:0]};
            default: load_val = '0;
        endcase
    end

    assign gpr_result = head_ent.mem_ren ? load_val
                      : (head_ent.csr_sel ? head_ent.csrrdata : head_ent.alu_result);
    assign byp_en     = head_valid & ~head_ent.mem_wen & head_done;

    assign ms.ms_allowin          = allowin;
    assign ms.ms_to_ws_valid      = to_ws_valid;
    assign ms.ms_to_ws_bus        = to_ws_valid
        ? {head_ent.gpr_wen, head_ent.rd, gpr_result,
           head_ent.csr_wen, head_ent.csr, head_ent.csr_result}
        : '0;
    assign ms.debug_ms_to_ws_bus  = to_ws_valid ? dbg_q[head_q] : '0;
    assign ms.ms_to_ds_bypass_bus = {
        (byp_en & head_ent.gpr_wen) ? head_ent.rd         : GPR_ADDR_WD'(0),
        (byp_en & head_ent.gpr_wen) ? gpr_result          : WORD_WD'(0),
        (byp_en & head_ent.csr_wen) ? head_ent.csr        : CSR_ADDR_WD'(0),
        (byp_en & head_ent.csr_wen) ? head_ent.csr_result : WORD_WD'(0)};
    assign ms.ms_data_stall       = |load_wait;
    assign ms.ms_resp_err         = resp_err_q;

    // Queue control: occupancy, done flags, pointers, sticky error.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q     <= '0;
            done_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            resp_err_q  <= 1'b0;
            first_cyc_q <= 1'b1;
        end else begin
            first_cyc_q <= 1'b0;
            if (fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_WD'(1);
            end
            if (resp_take) begin
                done_q[resp_idx] <= 1'b1;
            end
            // Placed after retire so a full-queue enqueue into the freed slot wins.
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= ~(es_ent.mem_ren | es_ent.mem_wen);
                tail_q          <= tail_q + PTR_WD'(1);
            end
            count_q <= count_q + CNT_WD'(enq) - CNT_WD'(fire);
            if (resp_orphan) begin
                resp_err_q <= 1'b1;
            end
        end
    end

    // Entry payload storage; qualified by valid_q, so no reset needed.
    always_ff @(posedge i_clk) begin
        if (enq) begin
            ent_q[tail_q] <= es_ent;
            dbg_q[tail_q] <= ms.debug_es_to_ms_bus;
        end
        if (resp_take) begin
            rdata_q[resp_idx] <= ms.data_sram_rdata;
        end
    end

`ifdef YSYX_22050710_MS_PERF_EN
    logic [63:0] perf_retire_q;
    logic [63:0] perf_stall_q;

    // Retire count and cycles the head sits waiting on its response.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            perf_retire_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_retire_q <= perf_retire_q + 64'(fire);
            perf_stall_q  <= perf_stall_q + 64'(head_valid & ~head_done);
        end
    end

    assign ms.perf_retire_cnt = perf_retire_q;
    assign ms.perf_stall_cnt  = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_22050710_mem_stage_mo.sv
module tb_ysyx_22050710_mem_stage_mo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050710_mem_stage_mo_if ifc ();

    ysyx_22050710_mem_stage_mo dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .ms     (ifc.slave)
    );

    typedef struct {
        logic [4:0]   rd;
        logic [11:0]  csr;
        logic         gpr_wen;
        logic         csr_wen;
        logic         mem_ren;
        logic         mem_wen;
        logic [2:0]   mem_op;
        logic         csr_sel;
        logic [63:0]  csrrdata;
        logic [63:0]  alu;
        logic [63:0]  csr_res;
        logic [63:0]  rdata;
        logic [160:0] dbg;
        logic         done;
    } ent_t;

    ent_t mq[$];
    int   checks = 0;
    int   failures = 0;
    logic err_m = 1'b0;
    logic post_rst = 1'b0;
    longint unsigned retire_m = 0;
    longint unsigned stall_m = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [216:0] pack(input ent_t e);
        return {e.rd, e.csr, e.gpr_wen, e.csr_wen, e.mem_ren, e.mem_wen, e.mem_op,
                e.csr_sel, e.csrrdata, e.alu, e.csr_res};
    endfunction

    // Load result from size/sign rules: take 2^op[1:0] bytes at the byte offset.
    function automatic logic [63:0] load_ref(input logic [2:0] op, input logic [2:0] off,
                                             input logic [63:0] rdata);
        logic [63:0] v;
        logic [63:0] mask;
        int nb;
        if (op == 3'b111) return 64'd0;
        v    = rdata >> (8 * int'(off));
        nb   = 1 << op[1:0];
        mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        v    = v & mask;
        if (!op[2] && ((v >> (8 * nb - 1)) & 64'd1) != 0) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [63:0] gpr_ref(input ent_t e);
        if (e.mem_ren) return load_ref(e.mem_op, e.alu[2:0], e.rdata);
        return e.csr_sel ? e.csrrdata : e.alu;
    endfunction

    function automatic logic [146:0] ws_ref(input ent_t e);
        return {e.gpr_wen, e.rd, gpr_ref(e), e.csr_wen, e.csr, e.csr_res};
    endfunction

    function automatic logic [144:0] byp_ref(input ent_t e);
        logic g;
        logic c;
        if (!e.done || e.mem_wen) return '0;
        g = e.gpr_wen;
        c = e.csr_wen;
        return {g ? e.rd : 5'd0, g ? gpr_ref(e) : 64'd0, c ? e.csr : 12'd0, c ? e.csr_res : 64'd0};
    endfunction

    function automatic int find_pending();
        for (int i = 0; i < mq.size(); i++)
            if (!mq[i].done && (mq[i].mem_ren || mq[i].mem_wen)) return i;
        return -1;
    endfunction

    function automatic ent_t mk(input int kind);
        ent_t e;
        e.rd       = 5'($urandom);
        e.csr      = 12'($urandom);
        e.gpr_wen  = 1'($urandom);
        e.csr_wen  = 1'($urandom);
        e.mem_ren  = (kind == 2);
        e.mem_wen  = (kind == 3);
        e.mem_op   = 3'($urandom);
        e.csr_sel  = (kind == 1);
        e.csrrdata = {$urandom, $urandom};
        e.alu      = {$urandom, $urandom};
        e.csr_res  = {$urandom, $urandom};
        e.rdata    = {$urandom, $urandom};
        e.dbg      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        e.done     = 1'b0;
        return e;
    endfunction

    // One clock: drive at negedge, record handshakes before posedge, end at next negedge.
    task automatic step(input logic v, input ent_t e, input logic wsa, input logic dok);
        int pi;
        logic taken;
        pi = find_pending();
        ifc.es_to_ms_valid     = v;
        ifc.es_to_ms_bus       = pack(e);
        ifc.debug_es_to_ms_bus = e.dbg;
        ifc.ws_allowin         = wsa;
        ifc.data_sram_data_ok  = dok;
        ifc.data_sram_rdata    = (pi >= 0) ? mq[pi].rdata : {$urandom, $urandom};
        #3;
        taken = v && ifc.ms_allowin;
        if (dok && !post_rst) begin
            pi = find_pending();
            if (pi >= 0) mq[pi].done = 1'b1;
            else err_m = 1'b1;
        end
        post_rst = 1'b0;
        if (taken) begin
            e.done = !(e.mem_ren || e.mem_wen);
            mq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic wsa, input logic dok);
        ent_t z;
        z = mk(0);
        step(1'b0, z, wsa, dok);
    endtask

    task automatic do_reset();
        rst_n                  = 1'b0;
        ifc.es_to_ms_valid     = 1'b0;
        ifc.es_to_ms_bus       = '0;
        ifc.debug_es_to_ms_bus = '0;
        ifc.data_sram_data_ok  = 1'b0;
        ifc.data_sram_rdata    = '0;
        ifc.ws_allowin         = 1'b1;
        mq.delete();
        err_m    = 1'b0;
        retire_m = 0;
        stall_m  = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        post_rst = 1'b1;
    endtask

    // Monitor: compare every output against the queue model, pop on retire.
    initial begin
        logic exp_v;
        logic exp_stall;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                exp_v = (mq.size() > 0) && mq[0].done;
                chk("to_ws_valid", 256'(ifc.ms_to_ws_valid), 256'(exp_v));
                if (exp_v) begin
                    chk("ws_bus", 256'(ifc.ms_to_ws_bus), 256'(ws_ref(mq[0])));
                    chk("dbg_bus", 256'(ifc.debug_ms_to_ws_bus), 256'(mq[0].dbg));
                end
                chk("bypass", 256'(ifc.ms_to_ds_bypass_bus),
                    (mq.size() > 0) ? 256'(byp_ref(mq[0])) : 256'(0));
                exp_stall = 1'b0;
                foreach (mq[i]) if (mq[i].mem_ren && !mq[i].done) exp_stall = 1'b1;
                chk("stall", 256'(ifc.ms_data_stall), 256'(exp_stall));
                chk("allowin", 256'(ifc.ms_allowin),
                    256'((mq.size() < 4) || (exp_v && ifc.ws_allowin)));
                chk("resp_err", 256'(ifc.ms_resp_err), 256'(err_m));
`ifdef YSYX_22050710_MS_PERF_EN
                chk("perf_retire", 256'(ifc.perf_retire_cnt), 256'(retire_m));
                chk("perf_stall", 256'(ifc.perf_stall_cnt), 256'(stall_m));
`endif
                if (mq.size() > 0 && !mq[0].done) stall_m++;
                if (exp_v && ifc.ws_allowin) begin
                    void'(mq.pop_front());
                    retire_m++;
                end
            end
        end
    end

    initial begin
        ent_t e;
        int budget;
        @(negedge clk);
        do_reset();

        // Reset state, then a single ALU entry retires one cycle later.
        #1;
        chk("rst_allowin", 256'(ifc.ms_allowin), 256'(1));
        chk("rst_valid", 256'(ifc.ms_to_ws_valid), 256'(0));
        chk("rst_ws_bus", 256'(ifc.ms_to_ws_bus), 256'(0));
        chk("rst_bypass", 256'(ifc.ms_to_ds_bypass_bus), 256'(0));
        chk("rst_stall", 256'(ifc.ms_data_stall), 256'(0));
        e = mk(0); e.rd = 5'd5; e.alu = 64'h1234; e.gpr_wen = 1'b1;
        step(1'b1, e, 1'b0, 1'b0);
        #1;
        chk("alu_latency_valid", 256'(ifc.ms_to_ws_valid), 256'(1));
        chk("alu_result", 256'(ifc.ms_to_ws_bus[140:77]), 256'(64'h1234));
        idle(1'b1, 1'b0);

        // lb / lbu from byte 3 of 0x80000000.
        for (int k = 0; k < 2; k++) begin
            e = mk(2); e.mem_op = (k == 0) ? 3'b000 : 3'b100;
            e.alu = 64'h8000_0003; e.rdata = 64'h0000_0000_8000_0000;
            step(1'b1, e, 1'b1, 1'b0);
            idle(1'b0, 1'b1);
            #1;
            chk("load_valid", 256'(ifc.ms_to_ws_valid), 256'(1));
            chk(k == 0 ? "lb_result" : "lbu_result", 256'(ifc.ms_to_ws_bus[140:77]),
                k == 0 ? 256'(64'hFFFF_FFFF_FFFF_FF80) : 256'(64'h80));
            idle(1'b1, 1'b0);
        end

        // Fill with four loads, then respond to each and drain in order.
        for (int k = 0; k < 4; k++) step(1'b1, mk(2), 1'b1, 1'b0);
        #1;
        chk("full_allowin", 256'(ifc.ms_allowin), 256'(0));
        chk("full_stall", 256'(ifc.ms_data_stall), 256'(1));
        for (int k = 0; k < 4; k++) idle(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) idle(1'b1, 1'b0);

        // Load then ALU while WB is blocked; bus must hold the load at head.
        step(1'b1, mk(2), 1'b0, 1'b0);
        step(1'b1, mk(0), 1'b0, 1'b0);
        idle(1'b0, 1'b1);
        for (int k = 0; k < 4; k++) idle(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) idle(1'b1, 1'b0);

        // Orphan response sets the sticky error; reset clears it and ignores
        // data_ok in the first cycle after reset.
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        #1;
        chk("orphan_err", 256'(ifc.ms_resp_err), 256'(1));
        do_reset();
        idle(1'b1, 1'b1);
        #1;
        chk("post_rst_err", 256'(ifc.ms_resp_err), 256'(0));
        chk("post_rst_allowin", 256'(ifc.ms_allowin), 256'(1));

`ifdef YSYX_22050710_MS_PERF_EN
        // Three retires with two cycles of the load waiting at head.
        do_reset();
        step(1'b1, mk(0), 1'b1, 1'b0);
        step(1'b1, mk(2), 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        step(1'b1, mk(0), 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        #1;
        chk("perf_retire_3", 256'(ifc.perf_retire_cnt), 256'(3));
        chk("perf_stall_2", 256'(ifc.perf_stall_cnt), 256'(2));
`endif

        // Randomized traffic with one mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            step(1'($urandom_range(99) < 60), mk(int'($urandom_range(3))),
                 1'($urandom_range(99) < 70),
                 (find_pending() >= 0) && ($urandom_range(99) < 50));
        end

        budget = 200;
        while (mq.size() > 0 && budget > 0) begin
            idle(1'b1, find_pending() >= 0);
            budget--;
        end
        chk("drain_timeout", 256'(mq.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
